// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed hex display: segment code table,
// blank pattern and PWM phase width.
package disp_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         PWM_W   = 4;

  // Active-low codes {dp,g,f,e,d,c,b,a}, dp bit held off; entry 0 at the LSB end.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble + decimal point to active-low 7-segment pattern.
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] sseg
);

  always_comb begin
    sseg    = SEG_TABLE[hex];
    sseg[7] = ~dp;
  end

endmodule

// File: rtl/disp_hex_mux_n.sv
// Time-multiplexed N-digit hex display driver with frame-shadowed data,
// leading-zero suppression, per-digit blanking and PWM brightness.
module disp_hex_mux_n
  import disp_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRESC_W-1:0]    presc;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] sh_hex;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blank;
  logic                  sh_lz;
  logic [N_DIGITS-1:0]   an_q;
  logic [7:0]            sseg_q;
  logic                  ft_q;

  logic                  presc_tc;
  logic                  frame_end;
  logic [PWM_W-1:0]      phase;
  logic [N_DIGITS-1:0]   lz_dark;
  logic                  lz_run;
  logic [N_DIGITS-1:0]   dark;
  logic [3:0]            sel_hex;
  logic                  sel_dp;
  logic                  sel_dark;
  logic [N_DIGITS-1:0]   sel_onehot;
  logic                  lit;
  logic [7:0]            dec_sseg;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            sseg_next;

  assign presc_tc  = &presc;
  assign frame_end = presc_tc && (idx == IDX_LAST);
  assign phase     = presc[PRESC_W-1 -: PWM_W];

  // Scan counters and frame-boundary shadow capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= '0;
      sh_hex   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
      ft_q     <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      ft_q  <= frame_end;
      if (presc_tc) begin
        idx <= frame_end ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        sh_hex   <= hex_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_mask;
        sh_lz    <= lz_en;
      end
    end
  end

  // Suppression runs down from the top digit and stops at the first digit
  // holding a non-zero nibble or a lit dp; digit 0 is always shown.
  always_comb begin
    lz_dark = '0;
    lz_run  = sh_lz;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (sh_hex[4*k +: 4] == 4'h0) && !sh_dp[k];
      lz_dark[k] = lz_run;
    end
  end

  assign dark = sh_blank | lz_dark;

  always_comb begin
    sel_hex    = 4'h0;
    sel_dp     = 1'b0;
    sel_dark   = 1'b1;
    sel_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_hex       = sh_hex[4*k +: 4];
        sel_dp        = sh_dp[k];
        sel_dark      = dark[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  hex_to_sseg u_dec (
    .hex  (sel_hex),
    .dp   (sel_dp),
    .sseg (dec_sseg)
  );

  // bright is used live so a change shows on the very next output update.
  assign lit = (phase <= bright) && !sel_dark;

  always_comb begin
    an_next   = '1;
    sseg_next = SEG_OFF;
    if (lit) begin
      an_next   = ~sel_onehot;
      sseg_next = dec_sseg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= '1;
      sseg_q <= SEG_OFF;
    end else begin
      an_q   <= an_next;
      sseg_q <= sseg_next;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Directed bench for disp_hex_mux_n with 8 digits and 16-cycle digit slots.
module tb_disp_hex_mux_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hex_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_mask;
  logic        lz_en;
  logic [3:0]  bright;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  disp_hex_mux_n #(.N_DIGITS(8), .PRESC_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // segs holds the expected code per digit ({d7..d0}); FF marks a dark digit.
  // Sample k reflects scan position k (slot k/16, phase k%16) of the frame.
  task automatic check_frame(input string name, input logic [63:0] segs, input logic [3:0] br,
                             input int n, input int chg_k, input logic [31:0] chg_hex);
    logic [7:0] seg;
    logic [7:0] exp_an;
    logic [7:0] exp_sseg;
    logic       act;
    int         slot;
    int         ph;
    for (int k = 0; k < n; k++) begin
      step();
      slot     = k / 16;
      ph       = k % 16;
      seg      = segs[8*slot +: 8];
      act      = (seg != 8'hFF) && (ph <= int'(br));
      exp_an   = act ? ~(8'b1 << slot) : 8'hFF;
      exp_sseg = act ? seg : 8'hFF;
      check($sformatf("%s an k=%0d", name, k), {24'h0, an}, {24'h0, exp_an});
      check($sformatf("%s sseg k=%0d", name, k), {24'h0, sseg}, {24'h0, exp_sseg});
      check($sformatf("%s tick k=%0d", name, k), {31'h0, frame_tick}, {31'h0, (k == 127)});
      if (k == chg_k) hex_in = chg_hex;
    end
  endtask

  task automatic check_reset(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check($sformatf("%s an %0d", name, i), {24'h0, an}, 32'hFF);
      check($sformatf("%s sseg %0d", name, i), {24'h0, sseg}, 32'hFF);
      check($sformatf("%s tick %0d", name, i), {31'h0, frame_tick}, 32'h0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    hex_in     = 32'h0123_4567;
    dp_in      = 8'h00;
    blank_mask = 8'h00;
    lz_en      = 1'b0;
    bright     = 4'd15;
    check_reset("rst", 3);
    reset = 1'b0;

    // Shadow registers still zero: every digit shows 0.
    check_frame("f1", {8{8'hC0}}, 4'd15, 128, -1, 32'h0);
    lz_en = 1'b1;
    // Live data 01234567; hex_in changes at cycle 40 but this frame is unaffected.
    check_frame("f2", {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8},
                4'd15, 128, 40, 32'h0000_00A0);
    // Leading zeros suppressed down to digit 2.
    check_frame("f3", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hC0},
                4'd15, 128, -1, 32'h0);
    bright     = 4'd3;
    hex_in     = 32'h0000_0F00;
    dp_in      = 8'h01;
    blank_mask = 8'h80;
    lz_en      = 1'b0;
    // Same data at brightness 3: lit only for phases 0..3.
    check_frame("f4", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hC0},
                4'd3, 128, -1, 32'h0);
    bright = 4'd15;
    dp_in  = 8'h10;
    lz_en  = 1'b1;
    // Blank mask on digit 7, dp on digit 0, no suppression.
    check_frame("f5", {8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h8E, 8'hC0, 8'h40},
                4'd15, 128, -1, 32'h0);
    dp_in = 8'h01;
    lz_en = 1'b0;
    // Suppression stops at digit 4 whose dp is lit.
    check_frame("f6", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h8E, 8'hC0, 8'hC0},
                4'd15, 128, -1, 32'h0);
    // Partial frame into slot 3, then reset mid-slot.
    check_frame("f7", {8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h8E, 8'hC0, 8'h40},
                4'd15, 53, -1, 32'h0);
    reset = 1'b1;
    check_reset("midrst", 2);
    reset = 1'b0;
    check_frame("f8", {8{8'hC0}}, 4'd15, 128, -1, 32'h0);
    check_frame("f9", {8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h8E, 8'hC0, 8'h40},
                4'd15, 128, -1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
